mio_bridge: RTL

MIO_BRIDGE -- requirements
Module: mio_bridge

---
 rtl/mio_if.sv | 21 ++
 rtl/mio_bridge.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mio_if.sv
// CPU-side memory/IO bus between the controller and mio_bridge.
// The master drives requests and the slave returns read data and a completion pulse.
interface mio_if;
  logic        cpu_mio;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mio_ready;

  modport master (
    output cpu_mio, mem_read, mem_write, addr, wdata,
    input  rdata, mio_ready
  );

  modport slave (
    input  cpu_mio, mem_read, mem_write, addr, wdata,
    output rdata, mio_ready
  );
endinterface

// File: rtl/mio_bridge.sv
// Bridges single CPU bus accesses to a fixed-latency word RAM or a small IO window
// (GPIO, switches, free-running cycle counter), with a one-cycle ready pulse per access.
module mio_bridge #(
  parameter int unsigned RAM_LATENCY = 2,
  parameter logic [31:0] IO_BASE     = 32'hE000_0000
) (
  input  logic        clk,
  input  logic        reset,
  mio_if.slave        bus,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic [15:0] sw_in,
  output logic [31:0] gpio_out
);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, IO_ACC, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  wait_cnt_q, wait_cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [9:0]  word_addr_q, word_addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_s;
  logic        io_hit_s;
  logic        unused_addr_bits_s;

  // Only the word address and the decode nibble matter; the rest of addr is don't-care.
  assign unused_addr_bits_s = ^{bus.addr[27:12], bus.addr[1:0]};

  assign req_s    = bus.cpu_mio & (bus.mem_read | bus.mem_write);
  assign io_hit_s = (bus.addr[31:28] == IO_BASE[31:28]);

  // Next-state and datapath update for the access sequencer, IO registers and counter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    is_wr_d     = is_wr_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    we_d        = 1'b0;
    gpio_d      = gpio_q;
    cnt_d       = cnt_q + 32'd1;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          word_addr_d = bus.addr[11:2];
          wdata_d     = bus.wdata;
          is_wr_d     = bus.mem_write;
          if (io_hit_s) begin
            state_d = IO_ACC;
          end else begin
            state_d    = RAM_WAIT;
            wait_cnt_d = 3'(RAM_LATENCY - 32'd1);
            we_d       = bus.mem_write;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RAM_WAIT: begin
        if (wait_cnt_q == 3'd0) begin
          state_d = DONE;
          ready_d = 1'b1;
          if (!is_wr_q) begin
            rdata_d = ram_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - 3'd1;
        end
      end
      IO_ACC: begin
        state_d = DONE;
        ready_d = 1'b1;
        // word_addr_q[1:0] is the IO register offset (byte address bits 3:2).
        if (is_wr_q) begin
          case (word_addr_q[1:0])
            2'd0:    gpio_d = wdata_q;
            2'd2:    cnt_d  = wdata_q;
            default: gpio_d = gpio_q;
          endcase
        end else begin
          case (word_addr_q[1:0])
            2'd0:    rdata_d = gpio_q;
            2'd1:    rdata_d = {16'h0000, sw_in};
            2'd2:    rdata_d = cnt_q;
            default: rdata_d = 32'h0000_0000;
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 3'd0;
      is_wr_q     <= 1'b0;
      word_addr_q <= 10'd0;
      wdata_q     <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      gpio_q      <= 32'h0000_0000;
      cnt_q       <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      is_wr_q     <= is_wr_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      gpio_q      <= gpio_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ram_addr      = word_addr_q;
  assign ram_we        = we_q;
  assign ram_wdata     = wdata_q;
  assign gpio_out      = gpio_q;
  assign bus.rdata     = rdata_q;
  assign bus.mio_ready = ready_q;

endmodule
